// File: rtl/reg_ex_ma_pipe.sv
// EX/MA pipeline stage register: valid/ready handshake, flush bubble, optional skid entry,
// forwarding tap for the EX hazard unit and a saturating debug stall counter.
module reg_ex_ma_pipe #(
    parameter int NBITS = 32,
    parameter int REG_W = 5,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_flush,
    input  logic             i_pc_mux_ctrl,
    input  logic [NBITS-1:0] i_ALU_rslt,
    input  logic [NBITS-1:0] i_eff_addr,
    input  logic             i_flg_mem_op,
    input  logic             i_flg_mem_type,
    input  logic [1:0]       i_flg_mem_size,
    input  logic             i_flg_unsign,
    input  logic [REG_W-1:0] i_rd,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_flg_ALU_dst,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_pc_mux_ctrl,
    output logic [NBITS-1:0] o_ALU_rslt,
    output logic [NBITS-1:0] o_eff_addr,
    output logic             o_flg_mem_op,
    output logic             o_flg_mem_type,
    output logic [1:0]       o_flg_mem_size,
    output logic             o_flg_unsign,
    output logic [REG_W-1:0] o_rd,
    output logic [REG_W-1:0] o_rt,
    output logic             o_flg_ALU_dst,
    output logic             o_fwd_en,
    output logic [REG_W-1:0] o_fwd_reg,
    output logic [NBITS-1:0] o_fwd_data,
    output logic [CNT_W-1:0] o_stall_cnt,
    input  logic             i_cnt_clr
);

    typedef struct packed {
        logic             pc_mux_ctrl;
        logic [NBITS-1:0] alu_rslt;
        logic [NBITS-1:0] eff_addr;
        logic             mem_op;
        logic             mem_type;
        logic [1:0]       mem_size;
        logic             unsign;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rt;
        logic             alu_dst;
    } payload_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    payload_t         in_pl;
    payload_t         bubble_pl;
    payload_t         main_q;
    payload_t         skid_q;
    logic             valid_q;
    logic             skid_full_q;
    logic             xfer_in;
    logic             xfer_out;
    logic [CNT_W-1:0] stall_cnt_q;

    always_comb begin
        in_pl.pc_mux_ctrl = i_pc_mux_ctrl;
        in_pl.alu_rslt    = i_ALU_rslt;
        in_pl.eff_addr    = i_eff_addr;
        in_pl.mem_op      = i_flg_mem_op;
        in_pl.mem_type    = i_flg_mem_type;
        in_pl.mem_size    = i_flg_mem_size;
        in_pl.unsign      = i_flg_unsign;
        in_pl.rd          = i_rd;
        in_pl.rt          = i_rt;
        in_pl.alu_dst     = i_flg_ALU_dst;
    end

    // A flushed entry keeps its data but can no longer touch memory, the PC or rd
    always_comb begin
        bubble_pl             = main_q;
        bubble_pl.mem_op      = 1'b0;
        bubble_pl.alu_dst     = 1'b0;
        bubble_pl.pc_mux_ctrl = 1'b0;
    end

    assign o_ready  = (SKID != 0) ? !skid_full_q : (!valid_q || i_ready);
    assign xfer_in  = i_valid && o_ready;
    assign xfer_out = valid_q && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q      <= '0;
            skid_q      <= '0;
            valid_q     <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (i_flush) begin
            main_q      <= bubble_pl;
            valid_q     <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (SKID != 0) begin
            // o_ready is low while the skid is full, so a refill from skid never races xfer_in
            if (!valid_q || xfer_out) begin
                if (skid_full_q) begin
                    main_q      <= skid_q;
                    valid_q     <= 1'b1;
                    skid_full_q <= 1'b0;
                end else if (xfer_in) begin
                    main_q  <= in_pl;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end else if (xfer_in) begin
                skid_q      <= in_pl;
                skid_full_q <= 1'b1;
            end
        end else begin
            if (xfer_in) begin
                main_q  <= in_pl;
                valid_q <= 1'b1;
            end else if (xfer_out) begin
                valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (i_cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (valid_q && !i_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign o_valid        = valid_q;
    assign o_pc_mux_ctrl  = main_q.pc_mux_ctrl;
    assign o_ALU_rslt     = main_q.alu_rslt;
    assign o_eff_addr     = main_q.eff_addr;
    assign o_flg_mem_op   = main_q.mem_op;
    assign o_flg_mem_type = main_q.mem_type;
    assign o_flg_mem_size = main_q.mem_size;
    assign o_flg_unsign   = main_q.unsign;
    assign o_rd           = main_q.rd;
    assign o_rt           = main_q.rt;
    assign o_flg_ALU_dst  = main_q.alu_dst;
    assign o_stall_cnt    = stall_cnt_q;

    // Load data is not available until MA completes, so loads never feed the tap
    assign o_fwd_reg  = main_q.alu_dst ? main_q.rd : main_q.rt;
    assign o_fwd_data = main_q.alu_rslt;
    assign o_fwd_en   = valid_q && !(main_q.mem_op && !main_q.mem_type) && (o_fwd_reg != '0);

endmodule

// File: doc/reg_ex_ma_pipe.md
Name: reg_ex_ma_pipe

Overview:
Parametrised EX/MA pipeline stage register that replaces the plain always-load EX/MA register. It adds a valid/ready handshake, synchronous flush (bubble insertion) and an optional 2-entry skid buffer. It also provides a forwarding tap for the EX hazard unit and a saturating stall counter for debug. It sits between the ALU/address-generation stage and the memory-access stage.

Parameters:
NBITS, 32, width of ALU result and effective address.
REG_W, 5, width of register indices rd/rt.
SKID, 1, 0 = single register, combinational o_ready; 1 = main + skid entry, registered o_ready.
CNT_W, 16, width of stall counter.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  EX payload valid
o_ready  out  1  stage can accept payload
i_flush  in  1  synchronous flush (branch/exception)
i_pc_mux_ctrl  in  1  PC mux control
i_ALU_rslt  in  NBITS  ALU result
i_eff_addr  in  NBITS  effective address
i_flg_mem_op  in  1  1 = memory access
i_flg_mem_type  in  1  0 = load, 1 = store
i_flg_mem_size  in  2  access size
i_flg_unsign  in  1  unsigned load
i_rd, i_rt  in  REG_W each  destination candidates
i_flg_ALU_dst  in  1  1 = write rd, 0 = write rt
o_valid  out  1  MA payload valid
i_ready  in  1  MA stage accepts
o_pc_mux_ctrl … o_flg_ALU_dst  out  same widths as inputs  registered payload
o_fwd_en  out  1  forwarding tap valid
o_fwd_reg  out  REG_W  forwarded destination index
o_fwd_data  out  NBITS  forwarded value (= o_ALU_rslt)
o_stall_cnt  out  CNT_W  saturating stall count
i_cnt_clr  in  1  synchronous stall counter clear

Behaviour:
- Reset (i_rst_n low, async): o_valid=0, skid entry empty, every payload output 0, o_fwd_* 0, o_stall_cnt 0. o_ready=1 after reset in both modes. Reset mid-transfer discards all held data.
- Transfer in: i_valid && o_ready at the clock edge. Transfer out: o_valid && i_ready at the clock edge. Latency is 1 cycle from transfer-in to o_valid when the stage is empty.
- SKID=0:
  - o_ready = !o_valid || i_ready (combinational).
  - On transfer-in, load payload and set o_valid.
  - On transfer-out without transfer-in, clear o_valid.
  - Payload holds while o_valid && !i_ready.
- SKID=1:
  - o_ready = !skid_full, driven from a flop.
  - Main empty, or main draining: transfer-in loads main.
  - Main full and not draining: transfer-in loads skid; skid_full=1; o_ready falls next cycle.
  - Main draining with skid full: main<=skid, skid_full=0.
  - At most 2 entries. Order is preserved: skid data is always output before newer data.
- Flush (i_flush=1 at edge):
  - o_valid=0 and skid_full=0.
  - Any same-cycle transfer-in is discarded.
  - o_flg_mem_op, o_flg_ALU_dst and o_pc_mux_ctrl are forced to 0 (harmless bubble); other payload bits hold.
  - Flush has priority over every load and drain. A flush coinciding with transfer-out still counts that beat as accepted downstream.
- Forwarding:
  - o_fwd_reg = o_flg_ALU_dst ? o_rd : o_rt.
  - o_fwd_data = o_ALU_rslt.
  - o_fwd_en = o_valid && !(o_flg_mem_op && !o_flg_mem_type) && o_fwd_reg != 0. Loads are never forwarded.
  - All fwd outputs are combinational from main-entry registers.
- Stall counter:
  - Increments each cycle o_valid && !i_ready; saturates at 2^CNT_W-1 (no wrap).
  - i_cnt_clr sets it to 0 and has priority over increment.
  - Flush does not clear it.
- Payload widths pass through unmodified; no arithmetic on data.

Test Plan:
- Reset/first load: i_rst_n pulsed low mid-cycle -> all outputs 0 immediately. Then i_valid=1, ALU_rslt=0x0000_00AA, rd=3, ALU_dst=1, i_ready=1 -> next cycle o_valid=1, o_ALU_rslt=0xAA, o_fwd_en=1, o_fwd_reg=3.
- Back-pressure, SKID=1: stream A=1, B=2, C=3 with i_ready=0 from cycle 1 -> A held in main, B in skid, o_ready=0, C held upstream. Release i_ready -> output sequence exactly 1, 2, 3, no loss or duplication; o_stall_cnt equals the number of stalled cycles.
- SKID=0 back-pressure: same stream -> o_ready = i_ready while full; output sequence 1, 2, 3.
- Flush: main and skid full, i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_ready=1, o_flg_mem_op=0, o_fwd_en=0, incoming beat dropped.
- Forwarding rules: load (mem_op=1, mem_type=0, rt=7) -> o_fwd_en=0. Store/ALU op with dst reg 0 -> o_fwd_en=0. ALU op with rt=9, ALU_dst=0 -> o_fwd_reg=9, o_fwd_en=1.
- Counter saturation: CNT_W=4, hold o_valid=1 and i_ready=0 for 20 cycles -> o_stall_cnt=15. Then i_cnt_clr=1 -> 0.
